// File: rtl/spi_bridge_pkg.sv
// Shared widths, FSM encoding and byte-select helper for the SPI bus arbiter.
package spi_bridge_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [LEN_W-1:0]  len_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        NEXT   = 3'd4,
        FINISH = 3'd5
    } state_t;

    function automatic data_t sel_byte(input logic sel1, input data_t b0, input data_t b1);
        return sel1 ? b1 : b0;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester and SPI-master byte bus of the arbiter; err exists only with SPI_ARB_TIMEOUT_EN.
interface spi_bus_arbiter_if;
    import spi_bridge_pkg::*;

    logic  req0, req1;
    len_t  len0, len1;
    data_t tx0, tx1;
    logic  tx_pop0, tx_pop1;
    data_t rx_data0, rx_data1;
    logic  rx_valid0, rx_valid1;
    logic  gnt0, gnt1;
    logic  done0, done1;
    logic  m_start;
    data_t m_data_in;
    data_t m_data_out;
    logic  m_done;
`ifdef SPI_ARB_TIMEOUT_EN
    logic  err;
`endif

    modport master (
        input  req0, req1, len0, len1, tx0, tx1, m_data_out, m_done,
        output tx_pop0, tx_pop1, rx_data0, rx_data1, rx_valid0, rx_valid1,
               gnt0, gnt1, done0, done1, m_start, m_data_in
`ifdef SPI_ARB_TIMEOUT_EN
        , output err
`endif
    );

    modport slave (
        output req0, req1, len0, len1, tx0, tx1, m_data_out, m_done,
        input  tx_pop0, tx_pop1, rx_data0, rx_data1, rx_valid0, rx_valid1,
               gnt0, gnt1, done0, done1, m_start, m_data_in
`ifdef SPI_ARB_TIMEOUT_EN
        , input err
`endif
    );

endinterface

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last accepted winner (1 after reset).
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = req;
        if (req[0] && req[1]) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (accept && (|gnt)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester burst arbiter in front of an SPI byte master.
// SPI_ARB_TIMEOUT_EN adds a per-byte m_done timeout and the sticky err output.
module spi_bus_arbiter
    import spi_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               rst,
    spi_bus_arbiter_if.master bus
);

    state_t     state_q, state_d;
    logic [1:0] req, arb_gnt, owner_q, rx_valid_q;
    logic       arb_accept, m_done_q, done_edge, busy, tmo_hit;
    len_t       cnt_q;
    data_t      m_data_q, rx_data0_q, rx_data1_q, tx_sel;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    assign req        = {bus.req1, bus.req0};
    // Winner is latched on the IDLE->ARB edge so a request dropped during ARB cannot move the grant.
    assign arb_accept = (state_q == IDLE) && (|req);

    spi_rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (arb_accept),
        .gnt    (arb_gnt)
    );

    assign done_edge = bus.m_done & ~m_done_q;
    assign tx_sel    = sel_byte(owner_q[1], bus.tx0, bus.tx1);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit = (state_q == WAIT) && !done_edge && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == WAIT) ? tmo_q + 1'b1 : '0;
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = ARB;
            ARB:     state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (done_edge) begin
                    state_d = NEXT;
                end else if (tmo_hit) begin
                    state_d = FINISH;
                end
            end
            NEXT:    state_d = (cnt_q != '0) ? START : FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            cnt_q      <= '0;
            m_data_q   <= '0;
            m_done_q   <= 1'b0;
            rx_valid_q <= '0;
            rx_data0_q <= '0;
            rx_data1_q <= '0;
        end else begin
            state_q    <= state_d;
            m_done_q   <= bus.m_done;
            rx_valid_q <= '0;
            if (arb_accept) begin
                owner_q <= arb_gnt;
            end
            case (state_q)
                ARB:   cnt_q    <= owner_q[1] ? bus.len1 : bus.len0;
                START: m_data_q <= tx_sel;
                WAIT: begin
                    if (done_edge) begin
                        rx_valid_q <= owner_q;
                        if (owner_q[1]) begin
                            rx_data1_q <= bus.m_data_out;
                        end else begin
                            rx_data0_q <= bus.m_data_out;
                        end
                    end
                end
                NEXT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state_q == ARB) || (state_q == START) ||
                           (state_q == WAIT) || (state_q == NEXT);
    assign bus.gnt0      = busy & owner_q[0];
    assign bus.gnt1      = busy & owner_q[1];
    assign bus.tx_pop0   = (state_q == START) & owner_q[0];
    assign bus.tx_pop1   = (state_q == START) & owner_q[1];
    assign bus.m_start   = (state_q == START);
    assign bus.m_data_in = (state_q == START) ? tx_sel : m_data_q;
    assign bus.done0     = (state_q == FINISH) & owner_q[0];
    assign bus.done1     = (state_q == FINISH) & owner_q[1];
    assign bus.rx_valid0 = rx_valid_q[0];
    assign bus.rx_valid1 = rx_valid_q[1];
    assign bus.rx_data0  = rx_data0_q;
    assign bus.rx_data1  = rx_data1_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter; timeout steps run only with SPI_ARB_TIMEOUT_EN.
module tb_spi_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_bus_arbiter_if bus ();

    spi_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    // Requester byte tables, indexed by pops since the burst was armed.
    logic [7:0] tab0 [8] = '{default: 8'h00};
    logic [7:0] tab1 [8] = '{default: 8'h00};
    int pop0_cnt = 0, pop1_cnt = 0;
    int base0 = 0, base1 = 0;

    assign bus.tx0 = tab0[3'(pop0_cnt - base0)];
    assign bus.tx1 = tab1[3'(pop1_cnt - base1)];

    always @(posedge clk) begin
        if (bus.tx_pop0) pop0_cnt <= pop0_cnt + 1;
        if (bus.tx_pop1) pop1_cnt <= pop1_cnt + 1;
    end

    // SPI slave: answers each m_start with (byte ^ mask) four cycles later.
    logic       slave_en   = 1'b1;
    logic [7:0] slave_mask = 8'h00;
    logic [7:0] sl_data;
    int         sl_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.m_done     <= 1'b0;
            bus.m_data_out <= 8'h00;
            sl_cnt         <= 0;
            sl_data        <= 8'h00;
        end else begin
            bus.m_done <= 1'b0;
            if (sl_cnt != 0) begin
                sl_cnt <= sl_cnt - 1;
                if (sl_cnt == 1) begin
                    bus.m_done     <= 1'b1;
                    bus.m_data_out <= sl_data;
                end
            end else if (slave_en && bus.m_start) begin
                sl_cnt  <= 3;
                sl_data <= bus.m_data_in ^ slave_mask;
            end
        end
    end

    // Event logs gathered on the falling edge.
    logic [7:0] start_log [$];
    logic [7:0] rx0_log [$];
    logic [7:0] rx1_log [$];
    logic [7:0] gnt_log [$];
    int done0_n = 0, done1_n = 0, viol = 0, gap = 100, last_gap = 100;
    logic g0p = 1'b0, g1p = 1'b0;

    always @(negedge clk) begin
        logic r0, r1;
        r0 = bus.gnt0 & ~g0p;
        r1 = bus.gnt1 & ~g1p;
        if (bus.m_start)   start_log.push_back(bus.m_data_in);
        if (bus.rx_valid0) rx0_log.push_back(bus.rx_data0);
        if (bus.rx_valid1) rx1_log.push_back(bus.rx_data1);
        if (bus.done0)     done0_n++;
        if (bus.done1)     done1_n++;
        if ((bus.gnt0 & bus.gnt1) | (bus.tx_pop0 & bus.tx_pop1) | (bus.rx_valid0 & bus.rx_valid1) |
            (bus.m_start !== (bus.tx_pop0 | bus.tx_pop1)))
            viol++;
        if (r0) gnt_log.push_back(8'd0);
        if (r1) gnt_log.push_back(8'd1);
        if (r0 | r1) begin
            last_gap = gap;
            gap      = 0;
        end else if (!bus.gnt0 && !bus.gnt1) begin
            gap++;
        end
        g0p = bus.gnt0;
        g1p = bus.gnt1;
    end

    function automatic logic [7:0] at8(input logic [7:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One burst on requester id; request dropped `hold` cycles after the grant shows.
    task automatic run_burst(input bit id, input logic [2:0] len, input int hold);
        int k, d;
        d = id ? done1_n : done0_n;
        if (id) begin base1 = pop1_cnt; bus.len1 = len; bus.req1 = 1'b1; end
        else    begin base0 = pop0_cnt; bus.len0 = len; bus.req0 = 1'b1; end
        k = 0;
        while (!(id ? bus.gnt1 : bus.gnt0) && k < 20) begin cyc(1); k++; end
        check("gnt_seen", id ? bus.gnt1 : bus.gnt0, 1);
        cyc(hold);
        if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        k = 0;
        while ((id ? done1_n : done0_n) == d && k < 200) begin cyc(1); k++; end
        check("burst_done", (id ? done1_n : done0_n) - d, 1);
    endtask

    // Both requesters raise together for one byte each; each drops once granted.
    task automatic both_burst(input logic [7:0] b0, input logic [7:0] b1);
        int k, d;
        d = done1_n;
        base0 = pop0_cnt; tab0[0] = b0; bus.len0 = 3'd0;
        base1 = pop1_cnt; tab1[0] = b1; bus.len1 = 3'd0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        k = 0;
        while (done1_n == d && k < 80) begin
            cyc(1);
            k++;
            if (bus.gnt0) bus.req0 = 1'b0;
            if (bus.gnt1) bus.req1 = 1'b0;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("both_done1", done1_n - d, 1);
    endtask

    initial begin
        int s0, r0i, r1i, g0, d0, k;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.len0 = 3'd0;
        bus.len1 = 3'd0;
        cyc(2);

        check("rst_gnt",      {bus.gnt1, bus.gnt0}, 0);
        check("rst_tx_pop",   {bus.tx_pop1, bus.tx_pop0}, 0);
        check("rst_rx_valid", {bus.rx_valid1, bus.rx_valid0}, 0);
        check("rst_done",     {bus.done1, bus.done0}, 0);
        check("rst_m_start",  bus.m_start, 0);
        check("rst_m_data",   bus.m_data_in, 0);
        check("rst_rx_data",  {bus.rx_data1, bus.rx_data0}, 0);
`ifdef SPI_ARB_TIMEOUT_EN
        check("rst_err",      bus.err, 0);
`endif
        rst = 1'b1;
        cyc(2);

        // Simultaneous requests after reset: 0 first, then 1.
        slave_mask = 8'h81;
        g0 = gnt_log.size(); s0 = start_log.size(); r0i = rx0_log.size(); r1i = rx1_log.size();
        both_burst(8'h11, 8'h22);
        check("rr_order_n",  gnt_log.size() - g0, 2);
        check("rr_first",    at8(gnt_log, g0), 0);
        check("rr_second",   at8(gnt_log, g0 + 1), 1);
        check("rr_start0",   at8(start_log, s0), 8'h11);
        check("rr_start1",   at8(start_log, s0 + 1), 8'h22);
        check("rr_rx0",      at8(rx0_log, r0i), 8'h90);
        check("rr_rx1",      at8(rx1_log, r1i), 8'hA3);
        cyc(2);

        // Single-byte loopback burst.
        slave_mask = 8'h00;
        tab0[0] = 8'h3C;
        s0 = start_log.size(); r0i = rx0_log.size();
        run_burst(1'b0, 3'd0, 0);
        check("one_start_n", start_log.size() - s0, 1);
        check("one_start",   at8(start_log, s0), 8'h3C);
        check("one_rx_n",    rx0_log.size() - r0i, 1);
        check("one_rx",      at8(rx0_log, r0i), 8'h3C);
        cyc(3);
        check("hold_m_data", bus.m_data_in, 8'h3C);
        check("hold_rx0",    bus.rx_data0, 8'h3C);

        // Four-byte burst on requester 1.
        slave_mask = 8'h81;
        tab1[0] = 8'hA5; tab1[1] = 8'h5A; tab1[2] = 8'hFF; tab1[3] = 8'h00;
        s0 = start_log.size(); r1i = rx1_log.size(); k = pop1_cnt; d0 = done0_n;
        run_burst(1'b1, 3'd3, 0);
        check("len4_start_n", start_log.size() - s0, 4);
        check("len4_pop_n",   pop1_cnt - k, 4);
        check("len4_start0",  at8(start_log, s0),     8'hA5);
        check("len4_start1",  at8(start_log, s0 + 1), 8'h5A);
        check("len4_start2",  at8(start_log, s0 + 2), 8'hFF);
        check("len4_start3",  at8(start_log, s0 + 3), 8'h00);
        check("len4_rx_n",    rx1_log.size() - r1i, 4);
        check("len4_rx0",     at8(rx1_log, r1i),     8'h24);
        check("len4_rx1",     at8(rx1_log, r1i + 1), 8'hDB);
        check("len4_rx2",     at8(rx1_log, r1i + 2), 8'h7E);
        check("len4_rx3",     at8(rx1_log, r1i + 3), 8'h81);
        check("len4_no_done0", done0_n - d0, 0);
        cyc(2);

        // Request dropped one cycle after the grant: all three bytes still go.
        tab0[0] = 8'h01; tab0[1] = 8'h02; tab0[2] = 8'h03;
        s0 = start_log.size(); r0i = rx0_log.size(); g0 = gnt_log.size();
        run_burst(1'b0, 3'd2, 1);
        cyc(5);
        check("drop_start_n", start_log.size() - s0, 3);
        check("drop_rx_n",    rx0_log.size() - r0i, 3);
        check("drop_rx0",     at8(rx0_log, r0i),     8'h80);
        check("drop_rx1",     at8(rx0_log, r0i + 1), 8'h83);
        check("drop_rx2",     at8(rx0_log, r0i + 2), 8'h82);
        check("drop_gnt_n",   gnt_log.size() - g0, 1);

        // Request held through done: regranted after the two-cycle gap.
        tab1[0] = 8'hC3; tab1[1] = 8'hE7;
        base1 = pop1_cnt; bus.len1 = 3'd0;
        g0 = gnt_log.size(); r1i = rx1_log.size(); d0 = done1_n;
        bus.req1 = 1'b1;
        k = 0;
        while (done1_n - d0 < 2 && k < 100) begin cyc(1); k++; end
        bus.req1 = 1'b0;
        cyc(5);
        check("hold_done_n", done1_n - d0, 2);
        check("hold_gnt_n",  gnt_log.size() - g0, 2);
        check("hold_gap",    last_gap, 2);
        check("hold_rx0",    at8(rx1_log, r1i),     8'h42);
        check("hold_rx1",    at8(rx1_log, r1i + 1), 8'h66);

        // Reset while waiting on the second... first byte of a 4-byte burst.
        slave_en = 1'b0;
        tab0[0] = 8'h10; tab0[1] = 8'h20; tab0[2] = 8'h30; tab0[3] = 8'h40;
        base0 = pop0_cnt; bus.len0 = 3'd3; bus.req0 = 1'b1;
        s0 = start_log.size();
        k = 0;
        while (!bus.gnt0 && k < 20) begin cyc(1); k++; end
        bus.req0 = 1'b0;
        k = 0;
        while (start_log.size() == s0 && k < 20) begin cyc(1); k++; end
        check("rstb_started", start_log.size() - s0, 1);
        cyc(3);
        check("rstb_in_wait", bus.gnt0, 1);
        d0 = done0_n;
        rst = 1'b0;
        #1;
        check("rstb_gnt",      {bus.gnt1, bus.gnt0}, 0);
        check("rstb_m_start",  {bus.m_start, bus.tx_pop1, bus.tx_pop0}, 0);
        check("rstb_m_data",   bus.m_data_in, 0);
        check("rstb_rx_data",  {bus.rx_data1, bus.rx_data0}, 0);
        check("rstb_done",     {bus.done1, bus.done0, bus.rx_valid1, bus.rx_valid0}, 0);
        cyc(3);
        check("rstb_no_done",  done0_n - d0, 0);
        rst = 1'b1;
        slave_en = 1'b1;
        cyc(2);
        g0 = gnt_log.size(); r0i = rx0_log.size(); r1i = rx1_log.size();
        both_burst(8'h55, 8'h66);
        check("rstb_first",  at8(gnt_log, g0), 0);
        check("rstb_second", at8(gnt_log, g0 + 1), 1);
        check("rstb_rx0",    at8(rx0_log, r0i), 8'hD4);
        check("rstb_rx1",    at8(rx1_log, r1i), 8'hE7);
        cyc(2);

`ifdef SPI_ARB_TIMEOUT_EN
        // Silent slave: done after 16 WAIT cycles, sticky err until reset.
        slave_en = 1'b0;
        tab0[0] = 8'h9A; base0 = pop0_cnt; bus.len0 = 3'd0;
        s0 = start_log.size(); r0i = rx0_log.size(); d0 = done0_n;
        bus.req0 = 1'b1;
        k = 0;
        while (!bus.gnt0 && k < 20) begin cyc(1); k++; end
        bus.req0 = 1'b0;
        k = 0;
        while (start_log.size() == s0 && k < 20) begin cyc(1); k++; end
        k = 0;
        while (done0_n == d0 && k < 40) begin cyc(1); k++; end
        check("tmo_latency", k, 17);
        check("tmo_err",     bus.err, 1);
        check("tmo_no_rx",   rx0_log.size() - r0i, 0);
        cyc(10);
        check("tmo_err_sticky", bus.err, 1);
        rst = 1'b0;
        #1;
        check("tmo_err_clear", bus.err, 0);
        rst = 1'b1;
        slave_en = 1'b1;
        cyc(2);
`endif

        check("no_overlap", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum clk cycles to wait for m_done per byte (used only under REQ-024).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning asynchronous active-low reset (0 = reset).
REQ-004 SHALL have ports req0/req1, input, 1 each, meaning requester N wants a burst (level).
REQ-005 SHALL have ports len0/len1, input, 3 each, meaning burst byte count minus 1 (0 -> 1 byte, 7 -> 8 bytes), sampled at grant.
REQ-006 SHALL have ports tx0/tx1, input, 8 each, meaning the next MOSI byte of requester N, valid while gntN=1.
REQ-007 SHALL have ports tx_pop0/tx_pop1, output, 1 each, meaning a 1-cycle strobe that the current txN byte was consumed.
REQ-008 SHALL have ports rx_data0/rx_data1 (output, 8 each) and rx_valid0/rx_valid1 (output, 1 each), meaning a received MISO byte with a 1-cycle valid strobe.
REQ-009 SHALL have ports gnt0/gnt1 (output, 1 each) and done0/done1 (output, 1 each), meaning grant held for the whole burst and a 1-cycle burst-complete strobe.
REQ-010 SHALL have ports m_start (output, 1), m_data_in (output, 8), m_data_out (input, 8) and m_done (input, 1), meaning the SPI master byte interface.

Function
REQ-011 SHALL implement FSM states IDLE, ARB, START, WAIT, NEXT and FINISH.
REQ-012 IDLE SHALL go to ARB when req0|req1; ARB SHALL pick the winner, latch lenN into a 3-bit remaining counter, assert gntN and go to START.
REQ-013 Arbitration SHALL be round-robin: if both request, the requester not most recently granted wins; after reset requester 0 has priority.
REQ-014 START SHALL, for exactly one cycle, drive m_start=1, m_data_in=txN and tx_popN=1, then go to WAIT.
REQ-015 WAIT SHALL act on the rising edge of m_done (registered edge detect): capture m_data_out into rx_dataN, pulse rx_validN for one cycle and go to NEXT.
REQ-016 NEXT SHALL go to START and decrement the counter when the counter is nonzero, else go to FINISH.
REQ-017 FINISH SHALL pulse doneN for one cycle, deassert gntN in that cycle and return to IDLE; the minimum gap between bursts is 2 cycles.
REQ-018 Deasserting reqN mid-burst SHALL be ignored; the burst always completes its latched length.
REQ-019 reqN still high after doneN SHALL be a new request subject to round-robin.
REQ-020 At most one gnt, one tx_pop and one rx_valid SHALL be high in any cycle.
REQ-021 m_data_in SHALL hold its last value outside START; rx_dataN SHALL hold until the next capture.

Reset
REQ-022 On rst=0, all outputs (gnt, tx_pop, rx_valid, done, m_start, m_data_in, rx_data) SHALL be 0 immediately, the state SHALL be IDLE, the counter 0 and the round-robin pointer set to "requester 1 last".
REQ-023 Reset mid-burst SHALL abandon the burst with no done strobe; the first grant after release follows REQ-013.

Configuration
REQ-024 With SPI_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles and, on reaching TIMEOUT_CYCLES without an m_done edge, go to FINISH, pulse doneN and raise a sticky output err (1 bit) cleared only by reset.
REQ-025 Without SPI_ARB_TIMEOUT_EN, the err port and counter SHALL be absent and WAIT SHALL wait indefinitely.

Structure
REQ-026 State encoding, the 8-bit data width and the 3-bit length width SHALL live in shared package spi_bridge_pkg.
REQ-027 Round-robin selection SHALL be a sub-module spi_rr_arb2 (two req in, one-hot gnt out, pointer update on accept).

Verification
REQ-028 Single-byte burst: req0, len0=0, tx0=8'h3C, slave loopback -> one m_start with 8'h3C, rx_valid0 carrying the slave byte, then one done0.
REQ-029 Simultaneous req0=req1=1 after reset -> requester 0 served first, then requester 1; gnt never overlaps.
REQ-030 Burst length: len1=3, tx bytes A5,5A,FF,00 -> exactly 4 m_start/tx_pop1/rx_valid1 pulses in order, then done1.
REQ-031 req0 dropped one cycle after gnt0 with len0=2 -> 3 bytes are still transferred and done0 pulses.
REQ-032 rst=0 asserted during WAIT of a 4-byte burst -> all outputs are 0 the same cycle, no done, and a fresh burst succeeds after release.
REQ-033 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, m_done held low -> done0 and err=1 after 16 WAIT cycles; err stays 1 until reset.
